// File: rtl/bp_mc_to_io.sv
// Manycore-to-BlackParrot inbound bridge: turns endpoint remote load/store requests into
// uncached BP I/O commands, one outstanding. Optional watchdog: BP_MC_TO_IO_TIMEOUT_EN.
module bp_mc_to_io #(
  parameter int unsigned mc_data_width_p = 32,
  parameter int unsigned mc_addr_width_p = 28,
  parameter int unsigned io_addr_width_p = 40,
  parameter logic [io_addr_width_p-1:0] io_addr_base_p = 40'h00_2000_0000,
  parameter int unsigned timeout_cycles_p = 1024
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        in_v_i,
  input  logic [mc_data_width_p-1:0]  in_data_i,
  input  logic [3:0]                  in_mask_i,
  input  logic [mc_addr_width_p-1:0]  in_addr_i,
  input  logic                        in_we_i,
  output logic                        in_yumi_o,
  output logic [mc_data_width_p-1:0]  returning_data_o,
  output logic                        returning_v_o,
  output logic                        io_cmd_v_o,
  output logic                        io_cmd_we_o,
  output logic [io_addr_width_p-1:0]  io_cmd_addr_o,
  output logic [1:0]                  io_cmd_size_o,
  output logic [mc_data_width_p-1:0]  io_cmd_data_o,
  input  logic                        io_cmd_yumi_i,
  input  logic [mc_data_width_p-1:0]  io_resp_data_i,
  input  logic                        io_resp_v_i,
  output logic                        io_resp_ready_o,
  output logic                        busy_o,
  output logic                        error_o
);

  if (mc_data_width_p != 32 || timeout_cycles_p == 0) begin : g_cfg_check
    $error("bp_mc_to_io: only 32-bit data and a nonzero timeout are supported");
  end

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RETURN} state_e;

  typedef struct packed {
    logic       legal;
    logic [1:0] size;
    logic [1:0] off;
  } req_dec_t;

  // Loads always move a full word; stores must be an aligned 1/2/4-byte lane group.
  function automatic req_dec_t decode_req(input logic we, input logic [3:0] mask);
    req_dec_t d;
    d = '{legal: 1'b1, size: 2'd2, off: 2'd0};
    if (we) begin
      case (mask)
        4'b1111: d = '{legal: 1'b1, size: 2'd2, off: 2'd0};
        4'b0011: d = '{legal: 1'b1, size: 2'd1, off: 2'd0};
        4'b1100: d = '{legal: 1'b1, size: 2'd1, off: 2'd2};
        4'b0001: d = '{legal: 1'b1, size: 2'd0, off: 2'd0};
        4'b0010: d = '{legal: 1'b1, size: 2'd0, off: 2'd1};
        4'b0100: d = '{legal: 1'b1, size: 2'd0, off: 2'd2};
        4'b1000: d = '{legal: 1'b1, size: 2'd0, off: 2'd3};
        default: d = '{legal: 1'b0, size: 2'd0, off: 2'd0};
      endcase
    end
    return d;
  endfunction

  // {word_addr, 2'b00} + byte_offset is exactly {word_addr, byte_offset}.
  function automatic logic [io_addr_width_p-1:0] io_addr(input logic [mc_addr_width_p-1:0] a,
                                                         input logic [1:0] off);
    return io_addr_base_p + {{(io_addr_width_p-mc_addr_width_p-2){1'b0}}, a, off};
  endfunction

  function automatic logic [mc_data_width_p-1:0] lane_align(input logic [mc_data_width_p-1:0] d,
                                                            input logic [1:0] off);
    return d >> {off, 3'b000};
  endfunction

  state_e   state;
  req_dec_t dec;

  always_comb dec = decode_req(in_we_i, in_mask_i);

  assign in_yumi_o = in_v_i & ~reset_i & (state == IDLE);

`ifdef BP_MC_TO_IO_TIMEOUT_EN
  localparam int unsigned cnt_w_lp = $clog2(timeout_cycles_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(timeout_cycles_p - 1);
  logic [cnt_w_lp-1:0] wait_cnt;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state            <= IDLE;
      busy_o           <= 1'b0;
      error_o          <= 1'b0;
      returning_v_o    <= 1'b0;
      returning_data_o <= '0;
      io_cmd_v_o       <= 1'b0;
      io_cmd_we_o      <= 1'b0;
      io_cmd_addr_o    <= '0;
      io_cmd_size_o    <= 2'd0;
      io_cmd_data_o    <= '0;
      io_resp_ready_o  <= 1'b0;
`ifdef BP_MC_TO_IO_TIMEOUT_EN
      wait_cnt         <= '0;
`endif
    end else begin
      returning_v_o <= 1'b0;
      case (state)
        IDLE: begin
          if (in_v_i) begin
            busy_o <= 1'b1;
            if (!dec.legal) begin
              state            <= RETURN;
              returning_v_o    <= 1'b1;
              returning_data_o <= '0;
              error_o          <= 1'b1;
            end else begin
              state         <= SEND;
              io_cmd_v_o    <= 1'b1;
              io_cmd_we_o   <= in_we_i;
              io_cmd_addr_o <= io_addr(in_addr_i, dec.off);
              io_cmd_size_o <= dec.size;
              io_cmd_data_o <= in_we_i ? lane_align(in_data_i, dec.off) : '0;
            end
          end
        end
        SEND: begin
          if (io_cmd_yumi_i) begin
            state           <= WAIT;
            io_cmd_v_o      <= 1'b0;
            io_resp_ready_o <= 1'b1;
`ifdef BP_MC_TO_IO_TIMEOUT_EN
            wait_cnt        <= '0;
`endif
          end
        end
        WAIT: begin
          // A response landing on the timeout cycle takes priority over the watchdog.
          if (io_resp_v_i) begin
            state            <= RETURN;
            io_resp_ready_o  <= 1'b0;
            returning_v_o    <= 1'b1;
            returning_data_o <= io_cmd_we_o ? '0 : io_resp_data_i;
          end
`ifdef BP_MC_TO_IO_TIMEOUT_EN
          else if (wait_cnt == cnt_last_lp) begin
            state            <= RETURN;
            io_resp_ready_o  <= 1'b0;
            returning_v_o    <= 1'b1;
            returning_data_o <= 32'hDEAD_BEEF;
            error_o          <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RETURN: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bp_mc_to_io.md
# bp_mc_to_io

Inbound bridge from the manycore network into BlackParrot's I/O command port: accepts remote load/store requests delivered by a `bsg_manycore_endpoint_standard` in-request group and issues them as uncached BP I/O commands. Waits for the matching BP I/O response, then returns load data or a store acknowledgment on the endpoint's returning group. This is the manycore-initiated counterpart to the BP-to-manycore path. It sits beside that path on the same endpoint, with one request outstanding.

## Interface
Parameters:
- `mc_data_width_p`, 32, manycore word width; only 32 is supported.
- `mc_addr_width_p`, 28, manycore word-address width.
- `io_addr_width_p`, 40, BP physical address width.
- `io_addr_base_p`, 40'h00_2000_0000, base added to the translated byte address.
- `timeout_cycles_p`, 1024, watchdog limit; used only with the config macro.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `in_v_i`  in  1  endpoint request valid.
- `in_data_i`  in  32  store data, byte lanes per mask.
- `in_mask_i`  in  4  store byte mask.
- `in_addr_i`  in  `mc_addr_width_p`  word address.
- `in_we_i`  in  1  1 = store, 0 = load.
- `in_yumi_o`  out  1  request consumed.
- `returning_data_o`  out  32  response data to endpoint.
- `returning_v_o`  out  1  response valid; this output is never backpressured.
- `io_cmd_v_o`  out  1  BP I/O command valid.
- `io_cmd_we_o`  out  1  uncached write (1) or read (0).
- `io_cmd_addr_o`  out  `io_addr_width_p`  byte address.
- `io_cmd_size_o`  out  2  0 = 1 B, 1 = 2 B, 2 = 4 B.
- `io_cmd_data_o`  out  32  write data, LSB-aligned.
- `io_cmd_yumi_i`  in  1  command consumed.
- `io_resp_data_i`  in  32  read data, LSB-aligned.
- `io_resp_v_i`  in  1  response valid.
- `io_resp_ready_o`  out  1  ready for response.
- `busy_o`  out  1  transaction in flight (state ≠ IDLE).
- `error_o`  out  1  sticky: an illegal mask was seen, or a timeout occurred.

## Operation
- FSM states: IDLE, SEND, WAIT, RETURN.
- IDLE:
  - `in_yumi_o = in_v_i`, combinationally.
  - On acceptance, capture the request, translate it and go to SEND.
  - If the mask is illegal, skip SEND/WAIT: go to RETURN with data 0 and set `error_o`.
- Address translation: `io_cmd_addr_o = io_addr_base_p + ({in_addr_i, 2'b00} + byte_offset)`, zero-extended to `io_addr_width_p`.
- Loads:
  - Mask is ignored; size 4 B, byte_offset 0.
- Stores, legal masks:
  - 1111 → 4 B, offset 0.
  - 0011 / 1100 → 2 B, offset 0 / 2.
  - 0001 / 0010 / 0100 / 1000 → 1 B, offset 0 / 1 / 2 / 3.
  - Any other mask, including 0000, is illegal.
- Store data: `io_cmd_data_o = in_data_i >> (8*byte_offset)`.
- SEND:
  - `io_cmd_v_o = 1` with stable command fields.
  - On `io_cmd_yumi_i`, go to WAIT.
- WAIT:
  - `io_resp_ready_o = 1`.
  - When `io_resp_v_i` is high, capture the data (loads) or 0 (stores) and go to RETURN.
- RETURN:
  - `returning_v_o = 1` for exactly one cycle, then go to IDLE.
- Exactly one `returning_v_o` pulse is produced per accepted request.
- `io_resp_ready_o` is 0 outside WAIT, so early responses are held off.

## Timing
- Reset values:
  - State: IDLE.
  - All outputs 0, including `error_o`.
  - Command and data registers: 0.
- Reset mid-transaction:
  - Return to IDLE immediately.
  - Drop the transaction; no `returning_v_o` is issued.
- Minimum latency, cycle 0 = `in_yumi_o` high:
  - `io_cmd_v_o` rises in cycle 1.
  - With yumi in cycle 1, WAIT starts in cycle 2.
  - With the response in cycle 2, `returning_v_o` fires in cycle 3.
- Illegal mask: `returning_v_o` fires in cycle 1.
- Command fields are registered and held stable while `io_cmd_v_o` waits for yumi.
- Requests arriving while busy: `in_yumi_o` stays 0 and the request waits at the endpoint.
- Back-to-back requests: the next request can be accepted in the cycle after RETURN, because IDLE is re-entered.

## Configuration
- `BP_MC_TO_IO_TIMEOUT_EN` defined:
  - A `clog2(timeout_cycles_p+1)`-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches `timeout_cycles_p` with no response, go to RETURN with data 32'hDEAD_BEEF and set `error_o`.
  - A response arriving in the same cycle as the timeout wins.
  - A late response arriving after the timeout is accepted only if the block is back in WAIT; otherwise it stays held off at the BP side.
- Macro undefined:
  - No counter is built.
  - WAIT lasts indefinitely until a response arrives.

## Test plan
- Load: addr 28'h0000010, `io_resp_data_i` 32'h1234_5678 one cycle after the command is accepted → `io_cmd_addr_o` = 40'h00_2000_0040, size 2, we 0; `returning_data_o` = 32'h1234_5678 at cycle 3.
- Store: mask 0100, data 32'hAABB_CCDD, addr 0 → size 0, `io_cmd_addr_o` = 40'h00_2000_0002, `io_cmd_data_o[7:0]` = 8'hBB; `returning_v_o` pulses with data 0.
- Command backpressure: `io_cmd_yumi_i` held low for 5 cycles → `io_cmd_v_o` and its fields stay stable; a second `in_v_i` is not yumi'd until after RETURN.
- Illegal mask: store with mask 0101 → no `io_cmd_v_o`; `returning_v_o` at cycle 1 with data 0; `error_o` = 1 until reset.
- Reset mid-WAIT: assert `reset_i` for 1 cycle during WAIT → `busy_o` = 0 and no `returning_v_o` afterward; a new request is accepted normally.
- Timeout, with `BP_MC_TO_IO_TIMEOUT_EN` defined and `timeout_cycles_p` = 8: no response → `returning_data_o` = 32'hDEAD_BEEF after 8 WAIT cycles and `error_o` = 1.
